// File: rtl/tcdm_bank_responder_if.sv
// TCDM bus bundle between NB_PORTS initiators and one responder bank.
// Signal suffixes are from the responder's point of view.
interface tcdm_bank_responder_if #(
    parameter int NB_PORTS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic [NB_PORTS-1:0]                 req_i;
    logic [NB_PORTS-1:0][ADDR_WIDTH-1:0] add_i;
    logic [NB_PORTS-1:0]                 wen_i;
    logic [NB_PORTS-1:0][BE_WIDTH-1:0]   be_i;
    logic [NB_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NB_PORTS-1:0]                 gnt_o;
    logic [NB_PORTS-1:0]                 r_valid_o;
    logic [NB_PORTS-1:0][DATA_WIDTH-1:0] r_rdata_o;

    modport master (
        output req_i, add_i, wen_i, be_i, wdata_i,
        input  gnt_o, r_valid_o, r_rdata_o
    );

    modport slave (
        input  req_i, add_i, wen_i, be_i, wdata_i,
        output gnt_o, r_valid_o, r_rdata_o
    );
endinterface

// File: rtl/tcdm_bank_responder.sv
// Multi-port TCDM bank: round-robin grant of one port per cycle, word array
// access, and a single registered response slot steered back to the winner.
module tcdm_resp_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sel_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o
);
    assign r_valid_o = sel_i;
    assign r_rdata_o = sel_i ? rdata_i : '0;
endmodule

module tcdm_bank_responder #(
    parameter int NB_PORTS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_i,
    tcdm_bank_responder_if.slave   bus
);
    localparam int PTR_W = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef struct packed {
        logic                  vld;
        logic [PTR_W-1:0]      id;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]      win;
    logic [PTR_W:0]        sum;
    logic [PTR_W-1:0]      cand;
    logic                  gnt_any;
    logic [NB_PORTS-1:0]   gnt;
    logic [IDX_W-1:0]      idx;
    rsp_t                  rsp_q, rsp_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic [NB_PORTS-1:0]                 r_valid;
    logic [NB_PORTS-1:0][DATA_WIDTH-1:0] r_rdata;
    logic                                unused_add;

    // Search from rr_ptr upward with wrap; reset and stall both suppress the grant.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        win     = '0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < NB_PORTS; i++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NB_PORTS))
                sum = sum - (PTR_W+1)'(NB_PORTS);
            cand = sum[PTR_W-1:0];
            if (!gnt_any && bus.req_i[cand] && !stall_i && !rst_i) begin
                gnt_any   = 1'b1;
                win       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

    assign idx = bus.add_i[win][IDX_W+1:2];
    assign unused_add = ^bus.add_i;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any)
            rr_ptr_d = (win == PTR_W'(NB_PORTS - 1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        rsp_d      = '0;
        rsp_d.vld  = gnt_any;
        rsp_d.id   = win;
        if (gnt_any && bus.wen_i[win])
            rsp_d.data = mem_q[idx];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            rsp_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rsp_q    <= rsp_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (gnt_any && !bus.wen_i[win]) begin
            for (int b = 0; b < BE_WIDTH; b++)
                if (bus.be_i[win][b])
                    mem_q[idx][8*b +: 8] <= bus.wdata_i[win][8*b +: 8];
        end
    end

    for (genvar p = 0; p < NB_PORTS; p++) begin : g_lane
        tcdm_resp_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .sel_i     (rsp_q.vld && (rsp_q.id == PTR_W'(p))),
            .rdata_i   (rsp_q.data),
            .r_valid_o (r_valid[p]),
            .r_rdata_o (r_rdata[p])
        );
    end

    assign bus.gnt_o     = gnt;
    assign bus.r_valid_o = r_valid;
    assign bus.r_rdata_o = r_rdata;
endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder with a response scoreboard queue
// and a reference word array.
module tb_tcdm_bank_responder;
    logic clk = 1'b0;
    logic rst;
    logic stall;

    always #5 clk = ~clk;

    tcdm_bank_responder_if #(.NB_PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    tcdm_bank_responder #(
        .NB_PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(1024)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stall),
        .bus     (bus)
    );

    typedef struct {
        logic        vld;
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [1024];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int p, input logic r, input logic [31:0] a, input logic w,
                       input logic [3:0] be, input logic [31:0] d);
        bus.req_i[p]   = r;
        bus.add_i[p]   = a;
        bus.wen_i[p]   = w;
        bus.be_i[p]    = be;
        bus.wdata_i[p] = d;
    endtask

    // One cycle: check the response due now, check the grant, model the access.
    task automatic step(input string tag, input logic [3:0] eg);
        exp_t              e;
        logic [3:0]        ev;
        logic [3:0][31:0]  ed;
        int                p;
        int                idx;
        @(negedge clk);
        e = '{vld: 1'b0, port: 0, data: 32'h0};
        if (sbq.size() > 0) e = sbq.pop_front();
        ev = '0;
        ed = '0;
        if (e.vld) begin
            ev[e.port] = 1'b1;
            ed[e.port] = e.data;
        end
        chk({tag, ".r_valid"}, 128'(bus.r_valid_o), 128'(ev));
        chk({tag, ".r_rdata"}, 128'(bus.r_rdata_o), 128'(ed));
        chk({tag, ".gnt"}, 128'(bus.gnt_o), 128'(eg));
        p = -1;
        for (int k = 0; k < 4; k++) if (eg[k]) p = k;
        if (p >= 0) begin
            idx = int'(bus.add_i[p][11:2]);
            if (bus.wen_i[p]) begin
                sbq.push_back('{vld: 1'b1, port: p, data: model[idx]});
            end else begin
                for (int b = 0; b < 4; b++)
                    if (bus.be_i[p][b]) model[idx][8*b +: 8] = bus.wdata_i[p][8*b +: 8];
                sbq.push_back('{vld: 1'b1, port: p, data: 32'h0});
            end
        end else begin
            sbq.push_back('{vld: 1'b0, port: 0, data: 32'h0});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        rst   = 1'b1;
        stall = 1'b0;
        for (int p = 0; p < 4; p++) drv(p, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.r_valid", 128'(bus.r_valid_o), 128'h0);
        chk("reset.r_rdata", 128'(bus.r_rdata_o), 128'h0);
        chk("reset.gnt", 128'(bus.gnt_o), 128'h0);
        for (int p = 0; p < 4; p++) drv(p, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0);
        rst = 1'b0;

        // Basic write then read on port 0
        drv(0, 1'b1, 32'h40, 1'b0, 4'hF, 32'hDEADBEEF);
        step("wr0", 4'b0001);
        drv(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h0);
        step("rd0", 4'b0001);
        drv(0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0);
        step("idle0", 4'b0000);

        // Byte enables on port 1 (rr_ptr now 1)
        drv(1, 1'b1, 32'h80, 1'b0, 4'hF, 32'h11223344);
        step("be_full", 4'b0010);
        drv(1, 1'b1, 32'h80, 1'b0, 4'b0101, 32'hAABBCCDD);
        step("be_part", 4'b0010);
        drv(1, 1'b1, 32'h80, 1'b1, 4'h0, 32'h0);
        step("be_rd", 4'b0010);
        drv(1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0);
        step("be_idle", 4'b0000);
        chk("be_merge_model", 128'(model[32]), 128'h11BB33DD);

        // Address wrap on port 2
        drv(2, 1'b1, 32'h0000_0000, 1'b0, 4'hF, 32'h5);
        step("wrap_wr", 4'b0100);
        drv(2, 1'b1, 32'h0000_1000, 1'b1, 4'h0, 32'h0);
        step("wrap_rd", 4'b0100);
        drv(2, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0);

        // Port 3 brings rr_ptr back to 0
        drv(3, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0);
        step("rr_wrap", 4'b1000);

        // All ports read continuously
        drv(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h0);
        drv(1, 1'b1, 32'h80, 1'b1, 4'h0, 32'h0);
        drv(2, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0);
        drv(3, 1'b1, 32'h1000, 1'b1, 4'h0, 32'h0);
        step("all_a", 4'b0001);
        step("all_b", 4'b0010);
        step("all_c", 4'b0100);
        step("all_d", 4'b1000);
        step("all_e", 4'b0001);

        // Stall with ports 1 and 2 requesting; port 0 response still due
        bus.req_i[0] = 1'b0;
        bus.req_i[3] = 1'b0;
        stall = 1'b1;
        step("stall1", 4'b0000);
        step("stall2", 4'b0000);
        step("stall3", 4'b0000);
        stall = 1'b0;
        step("unstall1", 4'b0010);
        bus.req_i[1] = 1'b0;
        step("unstall2", 4'b0100);
        bus.req_i[2] = 1'b0;
        step("unstall_idle", 4'b0000);

        // Asynchronous reset with a read response pending
        drv(3, 1'b1, 32'h40, 1'b1, 4'h0, 32'h0);
        step("pre_rst", 4'b1000);
        e = sbq.pop_front();
        chk("pend.r_valid", 128'(bus.r_valid_o), 128'(4'b1000));
        chk("pend.r_rdata", 128'(bus.r_rdata_o[3]), 128'(e.data));
        #2 rst = 1'b1;
        #1;
        chk("async_rst.r_valid", 128'(bus.r_valid_o), 128'h0);
        chk("async_rst.r_rdata", 128'(bus.r_rdata_o), 128'h0);
        sbq.delete();
        for (int p = 0; p < 4; p++) drv(p, 1'b1, 32'h40, 1'b1, 4'h0, 32'h0);
        step("in_rst", 4'b0000);
        rst = 1'b0;
        step("post_rst", 4'b0001);
        for (int p = 0; p < 4; p++) drv(p, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0);
        step("flush", 4'b0000);
        step("final", 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
